// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - Fetch port, data port and memory bus bundle for mem_arbiter
interface mem_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_valid;
  logic [31:0] if_rdata;

  logic        dm_req;
  logic        dm_we;
  logic        dm_byte;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_gnt;
  logic        dm_valid;
  logic [31:0] dm_rdata;

  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  // Arbiter side
  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_byte, dm_addr, dm_wdata, mem_ack, mem_rdata,
    output if_gnt, if_valid, if_rdata, dm_gnt, dm_valid, dm_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, mem_be
  );

  // Requester and memory side
  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_byte, dm_addr, dm_wdata, mem_ack, mem_rdata,
    input  if_gnt, if_valid, if_rdata, dm_gnt, dm_valid, dm_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, mem_be
  );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - Fetch/data arbiter for one single-ported memory, one transaction outstanding
// Define MEM_ARBITER_FAIRNESS_EN to let a waiting fetch win after STARVE_MAX consecutive data grants.
module mem_arbiter #(
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM, DONE} state_t;

  state_t      state;
  state_t      state_nxt;
  logic        take_dm;
  logic        take_if;
  logic        starved;
  logic        issue_q;
  logic        done_dm_q;
  logic        mem_we_q;
  logic [3:0]  mem_be_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic [31:0] if_rdata_q;
  logic [31:0] dm_rdata_q;
  logic [3:0]  byte_be;

`ifdef MEM_ARBITER_FAIRNESS_EN
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  logic [3:0] dm_streak;

  assign starved = bus.if_req && (dm_streak == STARVE_LIM);

  always_ff @(posedge clk) begin
    if (!rst) begin
      dm_streak <= 4'd0;
    end else if (take_dm) begin
      dm_streak <= bus.if_req ? dm_streak + 4'd1 : 4'd0;
    end else if (take_if) begin
      dm_streak <= 4'd0;
    end
  end
`else
  assign starved = 1'b0;
`endif

  // Big-endian lanes: offset 0 lives in be[3]
  assign byte_be = 4'b1000 >> bus.dm_addr[1:0];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    take_dm      = 1'b0;
    take_if      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.dm_req && !starved) begin
          take_dm   = 1'b1;
          state_nxt = BUSY_DM;
        end else if (bus.if_req) begin
          take_if   = 1'b1;
          state_nxt = BUSY_IF;
        end
      end
      BUSY_IF, BUSY_DM: begin
        if (bus.mem_ack) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    bus.mem_en   = issue_q;
    bus.if_gnt   = issue_q && (state == BUSY_IF);
    bus.dm_gnt   = issue_q && (state == BUSY_DM);
    bus.if_valid = (state == DONE) && !done_dm_q;
    bus.dm_valid = (state == DONE) && done_dm_q;
  end

  // Request fields are latched at the grant decision and held for the whole BUSY phase
  always_ff @(posedge clk) begin
    if (!rst) begin
      issue_q     <= 1'b0;
      done_dm_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= 4'b0000;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      if_rdata_q  <= 32'd0;
      dm_rdata_q  <= 32'd0;
    end else begin
      issue_q <= take_dm || take_if;
      if (take_dm) begin
        done_dm_q <= 1'b1;
        mem_we_q  <= bus.dm_we;
        if (bus.dm_byte) begin
          mem_be_q    <= byte_be;
          mem_addr_q  <= bus.dm_addr;
          mem_wdata_q <= {4{bus.dm_wdata[7:0]}};
        end else begin
          mem_be_q    <= 4'b1111;
          mem_addr_q  <= bus.dm_addr & 32'hFFFF_FFFC;
          mem_wdata_q <= bus.dm_wdata;
        end
      end else if (take_if) begin
        done_dm_q   <= 1'b0;
        mem_we_q    <= 1'b0;
        mem_be_q    <= 4'b1111;
        mem_addr_q  <= bus.if_addr & 32'hFFFF_FFFC;
        mem_wdata_q <= 32'd0;
      end
      if ((state == BUSY_IF) && bus.mem_ack) begin
        if_rdata_q <= bus.mem_rdata;
      end
      if ((state == BUSY_DM) && bus.mem_ack) begin
        dm_rdata_q <= bus.mem_rdata;
      end
    end
  end

  assign bus.mem_we    = mem_we_q;
  assign bus.mem_be    = mem_be_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.dm_rdata  = dm_rdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - Directed vector bench for mem_arbiter (STARVE_MAX=3)
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mem_arbiter_if bus();

  mem_arbiter #(.STARVE_MAX(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        is_dm;
    logic        we;
    logic        byt;
    logic        drop;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          lat;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    logic [31:0] held;
    @(negedge clk);
    if (v.is_dm) begin
      bus.dm_req   = 1'b1;
      bus.dm_we    = v.we;
      bus.dm_byte  = v.byt;
      bus.dm_addr  = v.addr;
      bus.dm_wdata = v.wdata;
    end else begin
      bus.if_req  = 1'b1;
      bus.if_addr = v.addr;
    end
    @(negedge clk);
    check($sformatf("v%0d gnt", idx), {bus.if_gnt, bus.dm_gnt}, v.is_dm ? 32'd1 : 32'd2);
    check($sformatf("v%0d mem_en", idx), bus.mem_en, 1);
    check($sformatf("v%0d mem_we", idx), bus.mem_we, v.is_dm & v.we);
    check($sformatf("v%0d mem_addr", idx), bus.mem_addr, v.exp_addr);
    check($sformatf("v%0d mem_be", idx), bus.mem_be, v.exp_be);
    if (v.is_dm) check($sformatf("v%0d mem_wdata", idx), bus.mem_wdata, v.exp_wdata);
    held          = bus.mem_addr;
    bus.mem_rdata = v.rdata;
    bus.mem_ack   = (v.lat == 0);
    if (v.drop) begin
      bus.if_req = 1'b0;
      bus.dm_req = 1'b0;
    end
    for (int k = 1; k <= v.lat; k++) begin
      @(negedge clk);
      check($sformatf("v%0d wait quiet", idx),
            {bus.mem_en, bus.if_gnt, bus.dm_gnt, bus.if_valid, bus.dm_valid}, 0);
      check($sformatf("v%0d addr stable", idx), bus.mem_addr, held);
      bus.mem_ack = (k == v.lat);
    end
    @(negedge clk);
    bus.mem_ack = 1'b0;
    check($sformatf("v%0d valid", idx), {bus.if_valid, bus.dm_valid, bus.mem_en},
          v.is_dm ? 32'd2 : 32'd4);
    check($sformatf("v%0d rdata", idx), v.is_dm ? bus.dm_rdata : bus.if_rdata, v.rdata);
    bus.if_req = 1'b0;
    bus.dm_req = 1'b0;
    @(negedge clk);
    check($sformatf("v%0d idle", idx),
          {bus.mem_en, bus.if_gnt, bus.dm_gnt, bus.if_valid, bus.dm_valid}, 0);
  endtask

  task automatic check_zero(input string name);
    check({name, " flags"}, {bus.if_gnt, bus.if_valid, bus.dm_gnt, bus.dm_valid,
                             bus.mem_en, bus.mem_we, bus.mem_be}, 0);
    check({name, " mem_addr"}, bus.mem_addr, 0);
    check({name, " mem_wdata"}, bus.mem_wdata, 0);
    check({name, " if_rdata"}, bus.if_rdata, 0);
    check({name, " dm_rdata"}, bus.dm_rdata, 0);
  endtask

  initial begin
    logic [7:0] order;
    logic [7:0] exp_order;
    int         ng;
    int         n_if;
    logic       overlap;
    int         en_cnt;
    int         dv;
    int         iv;
    int         lat_cnt;
    int         first_dm;
    logic       prev_valid;

    //        dm  we   byt  drop addr          wdata         rdata         lat exp_addr      be       exp_wdata
    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h00400007, 32'h00000000, 32'h8C080004, 0, 32'h00400004, 4'b1111, 32'h00000000};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h10000002, 32'h000000A5, 32'h00000000, 0, 32'h10000002, 4'b0010, 32'hA5A5A5A5};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h20000013, 32'h13572468, 32'hDEADBEEF, 2, 32'h20000010, 4'b1111, 32'h13572468};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h3000000C, 32'h12345678, 32'h00000000, 1, 32'h3000000C, 4'b1111, 32'h12345678};
    vecs[4] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h10000001, 32'h000000C3, 32'hCAFEF00D, 1, 32'h10000001, 4'b0100, 32'hC3C3C3C3};
    vecs[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h10000003, 32'h12345677, 32'h00000000, 0, 32'h10000003, 4'b0001, 32'h77777777};
    vecs[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h10000000, 32'h000000FF, 32'h00000000, 3, 32'h10000000, 4'b1000, 32'hFFFFFFFF};
    vecs[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0000FFFE, 32'h00000000, 32'h01234567, 3, 32'h0000FFFC, 4'b1111, 32'h00000000};

    rst          = 1'b0;
    bus.if_req   = 1'b0;
    bus.if_addr  = 32'd0;
    bus.dm_req   = 1'b1;
    bus.dm_we    = 1'b0;
    bus.dm_byte  = 1'b0;
    bus.dm_addr  = 32'd0;
    bus.dm_wdata = 32'd0;
    bus.mem_ack  = 1'b0;
    bus.mem_rdata = 32'd0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    bus.dm_req = 1'b0;
    rst        = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // Stray ack while idle must not produce a valid or touch rdata
    @(negedge clk);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h55555555;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    check("idle ack valid", {bus.if_valid, bus.dm_valid, bus.mem_en}, 0);
    check("idle ack rdata", bus.if_rdata, 32'h01234567);

    // Ack held high through DONE and the following IDLE
    @(negedge clk);
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h00000008;
    @(negedge clk);
    check("done ack gnt", bus.if_gnt, 1);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h11112222;
    @(negedge clk);
    check("done ack valid", bus.if_valid, 1);
    bus.if_req    = 1'b0;
    bus.mem_rdata = 32'h99999999;
    @(negedge clk);
    check("done ack no 2nd valid", {bus.if_valid, bus.dm_valid}, 0);
    check("done ack rdata", bus.if_rdata, 32'h11112222);
    bus.mem_ack = 1'b0;
    @(negedge clk);

    // Reset in the middle of BUSY_DM, late ack must be discarded
    bus.dm_req   = 1'b1;
    bus.dm_we    = 1'b1;
    bus.dm_byte  = 1'b1;
    bus.dm_addr  = 32'h10000002;
    bus.dm_wdata = 32'h000000A5;
    @(negedge clk);
    check("rst mid gnt", bus.dm_gnt, 1);
    rst        = 1'b0;
    bus.dm_req = 1'b0;
    @(negedge clk);
    check_zero("rst mid");
    rst = 1'b1;
    @(negedge clk);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    check("rst late ack valid", {bus.if_valid, bus.dm_valid, bus.mem_en}, 0);
    check("rst late ack rdata", bus.dm_rdata, 0);

    // Both requesters held continuously, single-cycle memory
    order   = 8'd0;
    ng      = 0;
    n_if    = 0;
    overlap = 1'b0;
    @(negedge clk);
    bus.dm_req   = 1'b1;
    bus.dm_we    = 1'b0;
    bus.dm_byte  = 1'b0;
    bus.dm_addr  = 32'h00000100;
    bus.if_req   = 1'b1;
    bus.if_addr  = 32'h00000200;
    for (int c = 1; c <= 24; c++) begin
      @(negedge clk);
      if ((bus.if_gnt && bus.dm_gnt) || (bus.if_valid && bus.dm_valid) ||
          ((bus.if_gnt || bus.dm_gnt) && (bus.if_valid || bus.dm_valid))) overlap = 1'b1;
      if (bus.if_gnt || bus.dm_gnt) begin
        if (ng < 8) order[ng] = bus.dm_gnt;
        ng++;
      end
      if (bus.if_gnt) n_if++;
      bus.mem_ack   = bus.mem_en;
      bus.mem_rdata = 32'h0000A000 + 32'(c);
      if (c == 24) begin
        bus.dm_req = 1'b0;
        bus.if_req = 1'b0;
      end
    end
    bus.mem_ack = 1'b0;
`ifdef MEM_ARBITER_FAIRNESS_EN
    exp_order = 8'b0111_0111;
    check("fair if count", n_if, 2);
`else
    exp_order = 8'b1111_1111;
    check("fair if count", n_if, 0);
`endif
    check("fair grant count", ng, 8);
    check("fair order", order, exp_order);
    check("fair overlap", overlap, 0);
    @(negedge clk);

    // Simultaneous requests, ack four cycles into BUSY
    en_cnt     = 0;
    dv         = 0;
    iv         = 0;
    lat_cnt    = -1;
    first_dm   = -1;
    overlap    = 1'b0;
    prev_valid = 1'b0;
    bus.dm_req = 1'b1;
    bus.if_req = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if ((bus.if_gnt && bus.dm_gnt) || (bus.if_valid && bus.dm_valid) ||
          (bus.mem_en && (bus.if_valid || bus.dm_valid)) || (prev_valid && bus.mem_en)) overlap = 1'b1;
      prev_valid = bus.if_valid || bus.dm_valid;
      if (bus.mem_en) begin
        en_cnt++;
        lat_cnt = 0;
      end else if (lat_cnt >= 0) begin
        lat_cnt++;
      end
      if (first_dm < 0 && (bus.dm_gnt || bus.if_gnt)) first_dm = bus.dm_gnt ? 1 : 0;
      if (bus.dm_valid) begin
        dv++;
        bus.dm_req = 1'b0;
      end
      if (bus.if_valid) begin
        iv++;
        bus.if_req = 1'b0;
      end
      if (lat_cnt == 3) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'hBEEF0000 + 32'(c);
        lat_cnt       = -1;
      end else begin
        bus.mem_ack = 1'b0;
      end
    end
    check("lat4 mem_en count", en_cnt, 2);
    check("lat4 dm_valid count", dv, 1);
    check("lat4 if_valid count", iv, 1);
    check("lat4 first is dm", first_dm, 1);
    check("lat4 overlap", overlap, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
